// File: rtl/game_fsm.sv
// game_fsm - sequencing core of the 4-digit code-breaking game.
//
// Converts one-hot digit switches and a debounced confirm button into the
// game state, the secret target, the current guess, the remaining chances
// and a blink phase for the downstream HEX/LEDR display controller.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   confirm    in   debounced confirm button (active-high level)
//   sw[9:0]    in   digit switches, sw[k] high selects digit k
//   state      out  current game state
//   blink_on   out  blink phase (1 = lit)
//   target     out  secret digits, index 3 is the leftmost digit
//   guess      out  current guess digits
//   candidate  out  digit selected on sw (0 unless exactly one switch is up)
//   sw_valid   out  candidate acceptable at the current entry position
//   chances    out  guesses remaining

package game_types;
    typedef enum logic [3:0] {
        S_IDLE, S_SET_D3, S_SET_D2, S_SET_D1, S_SET_D0,
        S_GUESS_D3, S_GUESS_D2, S_GUESS_D1, S_GUESS_D0,
        S_SHOW_RESULT, S_WIN, S_LOSE
    } state_t;
endpackage

module game_fsm
    import game_types::*;
#(
    parameter int BLINK_HALF  = 12_500_000,
    parameter int MAX_CHANCES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       confirm,
    input  logic [9:0] sw,
    output state_t     state,
    output logic       blink_on,
    output logic [3:0] target [3:0],
    output logic [3:0] guess  [3:0],
    output logic [3:0] candidate,
    output logic       sw_valid,
    output logic [2:0] chances
);

    localparam int            CW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] BLINK_TERM = CW'(BLINK_HALF - 1);
    localparam logic [2:0]    CH_INIT    = 3'(MAX_CHANCES);

    state_t          state_q, state_d;
    logic [3:0][3:0] target_q, guess_q;
    logic [3:0]      cand_q, cand_d;
    logic            sw_valid_q, sw_valid_d;
    logic [2:0]      chances_q;
    logic            blink_q;
    logic [CW-1:0]   blink_cnt_q;
    logic            confirm_q;

    logic            cfm;
    logic            one_hot;
    logic [3:0]      ones;
    logic [3:0]      idx;
    logic            set_phase, guess_phase;
    logic [1:0]      pos;
    logic            wr_target, wr_guess, new_game, dec_chance;

    // True when cand already sits at an entry position above p.
    function automatic logic digit_taken(input logic [3:0] cand,
                                         input logic [3:0][3:0] digits,
                                         input logic [1:0] p);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > int'(p) && digits[k] == cand) hit = 1'b1;
        end
        return hit;
    endfunction

    // confirm_q resets high so a button held through reset never fires.
    assign cfm = confirm & ~confirm_q;

    // Switch decode and entry-position lookup.
    always_comb begin
        ones = 4'd0;
        idx  = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (sw[k]) begin
                ones = ones + 4'd1;
                idx  = 4'(k);
            end
        end
        one_hot = (ones == 4'd1);
        cand_d  = one_hot ? idx : 4'd0;

        set_phase   = 1'b0;
        guess_phase = 1'b0;
        pos         = 2'd0;
        case (state_q)
            S_SET_D3:   begin set_phase   = 1'b1; pos = 2'd3; end
            S_SET_D2:   begin set_phase   = 1'b1; pos = 2'd2; end
            S_SET_D1:   begin set_phase   = 1'b1; pos = 2'd1; end
            S_SET_D0:   begin set_phase   = 1'b1; pos = 2'd0; end
            S_GUESS_D3: begin guess_phase = 1'b1; pos = 2'd3; end
            S_GUESS_D2: begin guess_phase = 1'b1; pos = 2'd2; end
            S_GUESS_D1: begin guess_phase = 1'b1; pos = 2'd1; end
            S_GUESS_D0: begin guess_phase = 1'b1; pos = 2'd0; end
            default: ;
        endcase

        sw_valid_d = one_hot
                   & ~(set_phase   && digit_taken(cand_d, target_q, pos))
                   & ~(guess_phase && digit_taken(cand_d, guess_q,  pos));
    end

    // Next-state logic; every transition is gated by the confirm edge.
    always_comb begin
        state_d    = state_q;
        wr_target  = 1'b0;
        wr_guess   = 1'b0;
        new_game   = 1'b0;
        dec_chance = 1'b0;
        if (cfm) begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_SET_D3;
                    new_game = 1'b1;
                end
                S_SET_D3, S_SET_D2, S_SET_D1, S_SET_D0: begin
                    if (sw_valid_q) begin
                        wr_target = 1'b1;
                        case (state_q)
                            S_SET_D3: state_d = S_SET_D2;
                            S_SET_D2: state_d = S_SET_D1;
                            S_SET_D1: state_d = S_SET_D0;
                            default:  state_d = S_GUESS_D3;
                        endcase
                    end
                end
                S_GUESS_D3, S_GUESS_D2, S_GUESS_D1, S_GUESS_D0: begin
                    if (sw_valid_q) begin
                        wr_guess = 1'b1;
                        case (state_q)
                            S_GUESS_D3: state_d = S_GUESS_D2;
                            S_GUESS_D2: state_d = S_GUESS_D1;
                            S_GUESS_D1: state_d = S_GUESS_D0;
                            default: begin
                                state_d    = S_SHOW_RESULT;
                                dec_chance = 1'b1;
                            end
                        endcase
                    end
                end
                S_SHOW_RESULT: begin
                    if (guess_q == target_q)     state_d = S_WIN;
                    else if (chances_q == 3'd0)  state_d = S_LOSE;
                    else                         state_d = S_GUESS_D3;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            guess_q     <= '0;
            cand_q      <= 4'd0;
            sw_valid_q  <= 1'b0;
            chances_q   <= CH_INIT;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
            confirm_q   <= 1'b1;
        end else begin
            confirm_q  <= confirm;
            cand_q     <= cand_d;
            sw_valid_q <= sw_valid_d;
            state_q    <= state_d;

            if (new_game) begin
                target_q  <= '0;
                guess_q   <= '0;
                chances_q <= CH_INIT;
            end
            // The registered candidate is written, matching the sw_valid it was qualified with.
            if (wr_target) target_q[pos] <= cand_q;
            if (wr_guess)  guess_q[pos]  <= cand_q;
            if (dec_chance && chances_q != 3'd0) chances_q <= chances_q - 3'd1;

            // A state change restarts the blink so the newly active digit is lit at once.
            if (state_d != state_q) begin
                blink_cnt_q <= '0;
                blink_q     <= 1'b1;
            end else if (blink_cnt_q == BLINK_TERM) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign state     = state_q;
    assign blink_on  = blink_q;
    assign candidate = cand_q;
    assign sw_valid  = sw_valid_q;
    assign chances   = chances_q;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            target[k] = target_q[k];
            guess[k]  = guess_q[k];
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// Testbench for game_fsm: scenario tasks push expected snapshots into a
// scoreboard queue as stimulus is driven and pop/compare them once the
// DUT has had time to respond.
module tb_game_fsm;
    import game_types::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       confirm = 1'b0;
    logic [9:0] sw = 10'd0;
    state_t     state;
    logic       blink_on;
    logic [3:0] target [3:0];
    logic [3:0] guess  [3:0];
    logic [3:0] candidate;
    logic       sw_valid;
    logic [2:0] chances;

    game_fsm #(.BLINK_HALF(4), .MAX_CHANCES(5)) dut (
        .clk(clk), .rst_n(rst_n), .confirm(confirm), .sw(sw),
        .state(state), .blink_on(blink_on), .target(target), .guess(guess),
        .candidate(candidate), .sw_valid(sw_valid), .chances(chances)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Snapshot layout: {state[4], chances[3], target[16], guess[16], candidate[4], sw_valid, blink_on}
    localparam logic [44:0] M_CORE = {4'hF, 3'h7, 16'hFFFF, 16'hFFFF, 4'h0, 1'b0, 1'b0};
    localparam logic [44:0] M_SW   = {4'h0, 3'h0, 16'h0000, 16'h0000, 4'hF, 1'b1, 1'b0};
    localparam logic [44:0] M_BLK  = 45'd1;
    localparam logic [44:0] M_ALL  = {45{1'b1}};

    typedef struct {
        string       name;
        logic [44:0] val;
        logic [44:0] mask;
    } exp_t;

    exp_t sb[$];

    function automatic logic [44:0] snap();
        return {4'(state), chances, target[3], target[2], target[1], target[0],
                guess[3], guess[2], guess[1], guess[0], candidate, sw_valid, blink_on};
    endfunction

    function automatic exp_t want(string n, state_t s, int ch, logic [15:0] tg, logic [15:0] gs,
                                  int cand, bit vld, bit blk, logic [44:0] mask);
        exp_t e;
        e.name = n;
        e.val  = {4'(s), 3'(ch), tg, gs, 4'(cand), vld, blk};
        e.mask = mask;
        return e;
    endfunction

    task automatic set_sw(input logic [9:0] v);
        sw = v;
        @(negedge clk);
    endtask

    task automatic pulse();
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e; logic [44:0] obs;
        rst_n = 1'b0; confirm = 1'b0; sw = 10'h020;
        sb.push_back(want("reset_values", S_IDLE, 5, 16'h0, 16'h0, 0, 1'b0, 1'b1, M_ALL));
        repeat (2) @(negedge clk);
        e = sb.pop_front(); obs = snap(); checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
        end
    endtask

    task automatic test_blink_idle();
        exp_t e; logic [44:0] obs;
        sw = 10'd0; rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sb.push_back(want($sformatf("idle_blink_%0d", i), S_IDLE, 5, 16'h0, 16'h0,
                              0, 1'b0, ((i / 4) % 2) == 0, M_CORE | M_BLK));
            e = sb.pop_front(); obs = snap(); checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_set_target();
        exp_t e; logic [44:0] obs;
        int d [4];
        state_t nx [4];
        logic [15:0] tg;
        d  = '{1, 2, 3, 4};
        nx = '{S_SET_D2, S_SET_D1, S_SET_D0, S_GUESS_D3};
        sb.push_back(want("idle_to_set", S_SET_D3, 5, 16'h0, 16'h0, 0, 1'b0, 1'b1, M_CORE | M_BLK));
        pulse();
        e = sb.pop_front(); obs = snap(); checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
        end
        tg = 16'h0;
        for (int i = 0; i < 4; i++) begin
            tg[15 - 4*i -: 4] = 4'(d[i]);
            sb.push_back(want($sformatf("set_digit_%0d", i), nx[i], 5, tg, 16'h0, 0, 1'b0, 1'b1, M_CORE | M_BLK));
            set_sw(10'(1 << d[i]));
            pulse();
            e = sb.pop_front(); obs = snap(); checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
            end
        end
        // Two switches up: no candidate, and a confirm must be ignored.
        sb.push_back(want("two_bits_sw", S_IDLE, 0, 16'h0, 16'h0, 0, 1'b0, 1'b0, M_SW));
        set_sw(10'h006);
        e = sb.pop_front(); obs = snap(); checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
        end
        sb.push_back(want("two_bits_confirm", S_GUESS_D3, 5, 16'h1234, 16'h0, 0, 1'b0, 1'b0, M_CORE));
        pulse();
        e = sb.pop_front(); obs = snap(); checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
        end
    endtask

    task automatic test_win();
        exp_t e; logic [44:0] obs;
        int d [4];
        state_t nx [4];
        logic [15:0] gs;
        d  = '{1, 2, 3, 4};
        nx = '{S_GUESS_D2, S_GUESS_D1, S_GUESS_D0, S_SHOW_RESULT};
        gs = 16'h0;
        for (int i = 0; i < 4; i++) begin
            gs[15 - 4*i -: 4] = 4'(d[i]);
            sb.push_back(want($sformatf("win_guess_%0d", i), nx[i], (i == 3) ? 4 : 5,
                              16'h1234, gs, 0, 1'b0, 1'b1, M_CORE | M_BLK));
            set_sw(10'(1 << d[i]));
            pulse();
            e = sb.pop_front(); obs = snap(); checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
            end
        end
        sb.push_back(want("win_state",   S_WIN,    4, 16'h1234, 16'h1234, 0, 1'b0, 1'b1, M_CORE | M_BLK));
        sb.push_back(want("win_to_idle", S_IDLE,   4, 16'h1234, 16'h1234, 0, 1'b0, 1'b1, M_CORE | M_BLK));
        sb.push_back(want("new_game",    S_SET_D3, 5, 16'h0,    16'h0,    0, 1'b0, 1'b1, M_CORE | M_BLK));
        for (int i = 0; i < 3; i++) begin
            pulse();
            e = sb.pop_front(); obs = snap(); checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_repeat_digit();
        exp_t e; logic [44:0] obs;
        logic [9:0] swv [8];
        bit         pls [8];
        sw = 10'd0;
        // Alternating switch settings and confirms; each step has one expectation.
        swv = '{10'h080, 10'h080, 10'h080, 10'h080, 10'h100, 10'h100, 10'h002, 10'h004};
        pls = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b1};
        sb.push_back(want("rep_d3_sw7",   S_IDLE,   0, 16'h0,    16'h0, 7, 1'b1, 1'b0, M_SW));
        sb.push_back(want("rep_d3_write", S_SET_D2, 5, 16'h7000, 16'h0, 0, 1'b0, 1'b1, M_CORE | M_BLK));
        sb.push_back(want("rep_d2_sw7",   S_IDLE,   0, 16'h0,    16'h0, 7, 1'b0, 1'b0, M_SW));
        sb.push_back(want("rep_d2_ignored", S_SET_D2, 5, 16'h7000, 16'h0, 0, 1'b0, 1'b0, M_CORE));
        sb.push_back(want("rep_d2_sw8",   S_IDLE,   0, 16'h0,    16'h0, 8, 1'b1, 1'b0, M_SW));
        sb.push_back(want("rep_d2_write", S_SET_D1, 5, 16'h7800, 16'h0, 0, 1'b0, 1'b1, M_CORE | M_BLK));
        sb.push_back(want("rep_d1_write", S_SET_D0, 5, 16'h7810, 16'h0, 0, 1'b0, 1'b1, M_CORE | M_BLK));
        sb.push_back(want("rep_d0_write", S_GUESS_D3, 5, 16'h7812, 16'h0, 0, 1'b0, 1'b1, M_CORE | M_BLK));
        for (int i = 0; i < 8; i++) begin
            if (sw != swv[i]) set_sw(swv[i]);
            if (pls[i]) pulse();
            e = sb.pop_front(); obs = snap(); checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_lose();
        exp_t e; logic [44:0] obs;
        int d [4];
        state_t nx [4];
        logic [15:0] gs;
        d  = '{5, 6, 7, 8};
        nx = '{S_GUESS_D2, S_GUESS_D1, S_GUESS_D0, S_SHOW_RESULT};
        for (int r = 0; r < 5; r++) begin
            gs = (r == 0) ? 16'h0 : 16'h5678;
            for (int i = 0; i < 4; i++) begin
                gs[15 - 4*i -: 4] = 4'(d[i]);
                sb.push_back(want($sformatf("lose_r%0d_d%0d", r, i), nx[i], (i == 3) ? 4 - r : 5 - r,
                                  16'h7812, gs, 0, 1'b0, 1'b1, M_CORE | M_BLK));
                set_sw(10'(1 << d[i]));
                pulse();
                e = sb.pop_front(); obs = snap(); checks++;
                if ((obs & e.mask) !== (e.val & e.mask)) begin
                    errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
                end
                if (r == 0 && i == 0) begin
                    // Guess phase checks against the guess, not the target.
                    sb.push_back(want("guess_repeat_5", S_IDLE, 0, 16'h0, 16'h0, 5, 1'b0, 1'b0, M_SW));
                    sb.push_back(want("guess_target_digit_1", S_IDLE, 0, 16'h0, 16'h0, 1, 1'b1, 1'b0, M_SW));
                    for (int k = 0; k < 2; k++) begin
                        set_sw((k == 0) ? 10'h020 : 10'h002);
                        e = sb.pop_front(); obs = snap(); checks++;
                        if ((obs & e.mask) !== (e.val & e.mask)) begin
                            errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
                        end
                    end
                end
            end
            sb.push_back(want($sformatf("lose_result_%0d", r), (r == 4) ? S_LOSE : S_GUESS_D3, 4 - r,
                              16'h7812, 16'h5678, 0, 1'b0, 1'b1, M_CORE | M_BLK));
            pulse();
            e = sb.pop_front(); obs = snap(); checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
            end
        end
        sb.push_back(want("lose_to_idle", S_IDLE, 0, 16'h7812, 16'h5678, 0, 1'b0, 1'b1, M_CORE | M_BLK));
        pulse();
        e = sb.pop_front(); obs = snap(); checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
        end
    endtask

    task automatic test_held_confirm();
        exp_t e; logic [44:0] obs;
        pulse();
        for (int i = 1; i <= 4; i++) begin
            set_sw(10'(1 << i));
            pulse();
        end
        sb.push_back(want("held_confirm_one_step", S_GUESS_D2, 5, 16'h1234, 16'h5000, 0, 1'b0, 1'b0, M_CORE));
        set_sw(10'h020);
        confirm = 1'b1;
        repeat (100) @(negedge clk);
        confirm = 1'b0;
        @(negedge clk);
        e = sb.pop_front(); obs = snap(); checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
        end
    endtask

    task automatic test_reset_mid_game();
        exp_t e; logic [44:0] obs;
        set_sw(10'h040);
        pulse();
        sb.push_back(want("mid_reset_values", S_IDLE, 5, 16'h0, 16'h0, 0, 1'b0, 1'b1, M_ALL));
        sb.push_back(want("held_through_reset", S_IDLE, 5, 16'h0, 16'h0, 0, 1'b0, 1'b0, M_CORE));
        sb.push_back(want("after_reset_game", S_SET_D3, 5, 16'h0, 16'h0, 0, 1'b0, 1'b1, M_CORE | M_BLK));
        confirm = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        e = sb.pop_front(); obs = snap(); checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
        end
        repeat (3) @(negedge clk);
        confirm = 1'b0;
        @(negedge clk);
        e = sb.pop_front(); obs = snap(); checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
        end
        pulse();
        e = sb.pop_front(); obs = snap(); checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_blink_idle();
        test_set_target();
        test_win();
        test_repeat_digit();
        test_lose();
        test_held_confirm();
        test_reset_mid_game();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
